regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file for the core datapath; generalises the 32x32 2R1W file.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_rd_port.sv | 55 +++++
 rtl/regfile_mp.sv | 114 +++++++++++
 tb/tb_regfile_mp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types, default sizes and helpers for the multi-read-port register file.
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 32;
    localparam int unsigned DEF_NREAD = 2;

    // Ceiling log2; DEPTH is a power of two >= 2, so this is exact.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port with hardwired-zero entry and optional write-to-read bypass.
// Bypass is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [AW-1:0]    i_raddr,
    input  logic [WIDTH-1:0] i_mem_data,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic             w_zero_hit;
    logic             w_bypass_hit;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_rdata;

    assign w_zero_hit   = (ZERO_REG != 0) && (i_raddr == '0);
    assign w_bypass_hit = BYPASS && i_we && (i_waddr == i_raddr);

    // Zero-register forcing wins over bypass; nothing is visible while clearing.
    always_comb begin
        w_next = i_mem_data;
        if (!i_run || w_zero_hit) begin
            w_next = '0;
        end else if (w_bypass_hit) begin
            w_next = i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_next;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with a built-in clear sequencer.
// Optional write-to-read bypass is selected by the REGFILE_BYPASS_EN macro.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned NREAD    = DEF_NREAD,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr_req,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [NREAD*AW-1:0]    raddr,
    output logic [NREAD*WIDTH-1:0] rdata,
    output logic                   ready
);

    rf_state_t        r_state;
    logic [AW-1:0]    r_clr_ptr;
    logic             r_ready;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic             w_run;
    logic             w_clr_last;
    logic             w_user_we;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [WIDTH-1:0] w_wr_data;

    assign w_run      = (r_state == RUN);
    assign w_clr_last = (r_clr_ptr == AW'(DEPTH - 1));
    assign w_user_we  = w_run && we;

    // Clear sequencer owns the write port in INIT; user writes are ignored there.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = r_clr_ptr;
        w_wr_data = '0;
        if (!w_run) begin
            w_wr_en = 1'b1;
        end else if (we && !((ZERO_REG != 0) && (waddr == '0))) begin
            w_wr_en   = 1'b1;
            w_wr_addr = waddr;
            w_wr_data = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= INIT;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    if (w_clr_last) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + AW'(1);
                    end
                end
                RUN: begin
                    if (clr_req) begin
                        r_state   <= INIT;
                        r_clr_ptr <= '0;
                        r_ready   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= INIT;
                    r_clr_ptr <= '0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array is deliberately unreset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    assign ready = r_ready;

    for (genvar gi = 0; gi < int'(NREAD); gi++) begin : g_rd_port
        logic [AW-1:0] w_port_addr;
        assign w_port_addr = raddr[gi*AW +: AW];

        regfile_rd_port #(
            .WIDTH    (WIDTH),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd_port (
            .i_clk      (clk),
            .i_rst_n    (reset),
            .i_run      (w_run),
            .i_raddr    (w_port_addr),
            .i_mem_data (r_mem[w_port_addr]),
            .i_we       (w_user_we),
            .i_waddr    (waddr),
            .i_wdata    (wdata),
            .o_rdata    (rdata[gi*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (defaults: 32x32, 2 read ports, zero register).
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        clr_req;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic        ready;

    int n_cmp;
    int n_fail;

    regfile_mp #(
        .WIDTH    (32),
        .DEPTH    (32),
        .NREAD    (2),
        .ZERO_REG (1)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .clr_req (clr_req),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr   (raddr),
        .rdata   (rdata),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Clocks until ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            cyc();
            n++;
        end
    endtask

    task automatic read_all_zero(input string name);
        we = 1'b0;
        for (int a = 0; a < 32; a += 2) begin
            raddr = {5'(a + 1), 5'(a)};
            cyc();
            chk(name, rdata[31:0], 32'h0);
            chk(name, rdata[63:32], 32'h0);
        end
    endtask

    initial begin
        int n;
        n_cmp   = 0;
        n_fail  = 0;
        reset   = 1'b0;
        clr_req = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;

        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd1,  5'd2,  32'h0, 32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd5,  5'd3,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
        vecs[4] = '{1'b1, 5'd7,  32'h0000AAAA, 5'd31, 5'd1,  32'h0, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd7,  5'd2,  32'h0000AAAA, 32'h0};
        vecs[6] = '{1'b1, 5'd7,  32'h00001234, 5'd31, 5'd7,  32'hCAFEF00D,
                    BYP ? 32'h00001234 : 32'h0000AAAA};
        vecs[7] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd31, 32'h00001234, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 5'd2,  32'h00000055, 5'd2,  5'd5,
                    BYP ? 32'h00000055 : 32'h0, 32'hDEADBEEF};
        vecs[9] = '{1'b1, 5'd0,  32'h00000077, 5'd0,  5'd2,  32'h0, 32'h00000055};

        // Reset held, then exactly 32 clear cycles before ready.
        repeat (3) cyc();
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_rdata0", rdata[31:0], 32'h0);
        chk("reset_rdata1", rdata[63:32], 32'h0);
        reset = 1'b1;
        wait_ready(n);
        chk("init_cycles", 32'(n), 32'd32);
        read_all_zero("init_read");

        // Table-driven write/read vectors.
        foreach (vecs[i]) begin
            we    = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            cyc();
            chk($sformatf("vec%0d_p0", i), rdata[31:0], vecs[i].exp0);
            chk($sformatf("vec%0d_p1", i), rdata[63:32], vecs[i].exp1);
        end
        we = 1'b0;

        // Fill r1..r31, clear on request; writes and clr_req inside INIT are ignored.
        for (int i = 1; i < 32; i++) begin
            we    = 1'b1;
            waddr = 5'(i);
            wdata = 32'(i);
            cyc();
        end
        we    = 1'b0;
        raddr = {5'd31, 5'd17};
        cyc();
        chk("fill_r17", rdata[31:0], 32'd17);
        chk("fill_r31", rdata[63:32], 32'd31);
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        chk("clr_ready_low", {31'b0, ready}, 32'h0);
        n = 0;
        while (!ready && n < 100) begin
            we      = 1'b1;
            waddr   = 5'd9;
            wdata   = 32'hBAD0BAD0;
            clr_req = (n == 5);
            cyc();
            n++;
        end
        clr_req = 1'b0;
        chk("clr_cycles", 32'(n), 32'd32);
        read_all_zero("clr_read");

        // Write and clr_req in the same RUN cycle: write lands, then gets cleared.
        we      = 1'b1;
        waddr   = 5'd3;
        wdata   = 32'h33;
        clr_req = 1'b1;
        cyc();
        we      = 1'b0;
        clr_req = 1'b0;
        wait_ready(n);
        chk("wclr_cycles", 32'(n), 32'd32);
        raddr = {5'd3, 5'd3};
        cyc();
        chk("wclr_r3", rdata[31:0], 32'h0);

        // Reset at INIT cycle 10.
        clr_req = 1'b1;
        cyc();
        clr_req = 1'b0;
        repeat (10) cyc();
        #2 reset = 1'b0;
        #1;
        chk("rst_init_ready", {31'b0, ready}, 32'h0);
        chk("rst_init_rdata", rdata[31:0], 32'h0);
        cyc();
        reset = 1'b1;
        wait_ready(n);
        chk("rst_init_cycles", 32'(n), 32'd32);

        // Reset mid-RUN during a write.
        we    = 1'b1;
        waddr = 5'd4;
        wdata = 32'h44;
        raddr = '0;
        cyc();
        we    = 1'b0;
        raddr = {5'd4, 5'd4};
        cyc();
        chk("run_r4", rdata[31:0], 32'h44);
        we    = 1'b1;
        wdata = 32'h99;
        #2 reset = 1'b0;
        #1;
        chk("rst_run_ready", {31'b0, ready}, 32'h0);
        chk("rst_run_rdata0", rdata[31:0], 32'h0);
        chk("rst_run_rdata1", rdata[63:32], 32'h0);
        cyc();
        we    = 1'b0;
        reset = 1'b1;
        wait_ready(n);
        chk("rst_run_cycles", 32'(n), 32'd32);
        cyc();
        chk("rst_run_r4", rdata[31:0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
